// File: rtl/pcie_tx_ab_commit_merge_pkg.sv
// Shared definitions for the TX A/B merge with write-commit return path.
// Holds TLP header field positions, fmt_type encodings, the arbiter state
// type and a small header decode helper.
package pcie_tx_ab_commit_merge_pkg;

  localparam int unsigned HDR_FMT_TYPE_LSB = 24;  // 8-bit fmt_type field
  localparam int unsigned HDR_TAG_LSB      = 40;  // 8-bit tag field
  localparam logic [7:0]  FMT_MWR32        = 8'h40;
  localparam logic [7:0]  FMT_MWR64        = 8'h60;
  localparam logic [7:0]  CPL_NODATA       = 8'h0A;
  localparam int unsigned HDR_BYTES        = 32;

  typedef enum logic [1:0] {
    StIdle,
    StAPkt,
    StBPkt
  } arb_state_e;

  function automatic logic is_mem_write(input logic [7:0] fmt_type);
    return (fmt_type == FMT_MWR32) || (fmt_type == FMT_MWR64);
  endfunction

endpackage

// File: rtl/pcie_tx_ab_commit_merge_commit_tag_fifo.sv
// commit_tag_fifo: synchronous FIFO of write-commit tags.
// Ports:
//   clk, rst        clock, synchronous active-high reset (empties the FIFO)
//   push, push_data write request / tag; ignored when full
//   pop, pop_data   read request / head-of-queue tag; pop ignored when empty
//   count           occupancy, 0..DEPTH
//   full, empty     occupancy flags
module commit_tag_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/pcie_tx_ab_commit_merge.sv
// pcie_tx_ab_commit_merge: packet-atomic round-robin merge of AFU TX streams
// A and B onto one output, plus a write-commit return stream (rx_b) that
// emits one CplD-less completion header per memory write sent from A.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   tx_a_*                   AXI-S TX A (writes, reads, other TLPs)
//   tx_b_*                   AXI-S TX B (reads, interrupts)
//   out_*                    merged AXI-S toward the PF/VF mux
//   rx_b_*                   single-beat commit completions back to the AFU
module pcie_tx_ab_commit_merge
  import pcie_tx_ab_commit_merge_pkg::*;
#(
  parameter int unsigned DATA_W       = 512,
  parameter int unsigned USER_W       = 10,
  parameter int unsigned COMMIT_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tx_a_tvalid,
  output logic                tx_a_tready,
  input  logic                tx_a_tlast,
  input  logic [DATA_W-1:0]   tx_a_tdata,
  input  logic [DATA_W/8-1:0] tx_a_tkeep,
  input  logic [USER_W-1:0]   tx_a_tuser,
  input  logic                tx_b_tvalid,
  output logic                tx_b_tready,
  input  logic                tx_b_tlast,
  input  logic [DATA_W-1:0]   tx_b_tdata,
  input  logic [DATA_W/8-1:0] tx_b_tkeep,
  input  logic [USER_W-1:0]   tx_b_tuser,
  output logic                out_tvalid,
  input  logic                out_tready,
  output logic                out_tlast,
  output logic [DATA_W-1:0]   out_tdata,
  output logic [DATA_W/8-1:0] out_tkeep,
  output logic [USER_W-1:0]   out_tuser,
  output logic                rx_b_tvalid,
  input  logic                rx_b_tready,
  output logic                rx_b_tlast,
  output logic [DATA_W-1:0]   rx_b_tdata,
  output logic [DATA_W/8-1:0] rx_b_tkeep,
  output logic [USER_W-1:0]   rx_b_tuser
);

  localparam int unsigned KEEP_W = DATA_W / 8;
  localparam int unsigned CNT_W  = $clog2(COMMIT_DEPTH) + 1;

  arb_state_e state_q, state_d;
  logic       favour_a_q, favour_a_d;
  logic       rst_d1_q;
  logic       sop_q;
  logic [7:0] tag_q;
  logic       is_wr_q;

  logic       live;
  logic       a_elig, b_elig, grant_a, grant_b, out_hs;
  logic [7:0] hdr_tag;
  logic       hdr_wr, a_sop_hs, commit_wr;

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]       fifo_pop_data;
  logic [CNT_W-1:0] fifo_count;
  logic             unused_fifo_count;

  // Handshakes are held off in the reset cycle and the cycle after it.
  assign live = ~rst & ~rst_d1_q;

  always_comb begin
    state_d    = state_q;
    favour_a_d = favour_a_q;
    grant_a    = 1'b0;
    grant_b    = 1'b0;
    a_elig     = tx_a_tvalid & ~fifo_full;
    b_elig     = tx_b_tvalid;

    unique case (state_q)
      StIdle: begin
        if (live) begin
          if (a_elig && (favour_a_q || !b_elig)) grant_a = 1'b1;
          else if (b_elig)                        grant_b = 1'b1;
        end
      end
      StAPkt:  grant_a = live;
      StBPkt:  grant_b = live;
      default: ;
    endcase

    out_tvalid = 1'b0;
    out_tlast  = 1'b0;
    out_tdata  = '0;
    out_tkeep  = '0;
    out_tuser  = '0;
    if (grant_a) begin
      out_tvalid = tx_a_tvalid;
      out_tlast  = tx_a_tlast;
      out_tdata  = tx_a_tdata;
      out_tkeep  = tx_a_tkeep;
      out_tuser  = tx_a_tuser;
    end else if (grant_b) begin
      out_tvalid = tx_b_tvalid;
      out_tlast  = tx_b_tlast;
      out_tdata  = tx_b_tdata;
      out_tkeep  = tx_b_tkeep;
      out_tuser  = tx_b_tuser;
    end
    tx_a_tready = grant_a & out_tready;
    tx_b_tready = grant_b & out_tready;
    out_hs      = out_tvalid & out_tready;

    // A grant made in idle is locked in even if the first beat stalls, so the
    // presented beat never changes source; only a completed single-beat packet
    // stays in idle.
    if (state_q == StIdle) begin
      if (grant_a || grant_b) begin
        favour_a_d = grant_b;
        if (!(out_hs && out_tlast)) state_d = grant_a ? StAPkt : StBPkt;
      end
    end else if (out_hs && out_tlast) begin
      state_d = StIdle;
    end
  end

  assign hdr_tag  = tx_a_tdata[HDR_TAG_LSB +: 8];
  assign hdr_wr   = is_mem_write(tx_a_tdata[HDR_FMT_TYPE_LSB +: 8]);
  assign a_sop_hs = grant_a & out_hs & sop_q;
  // A single-beat packet commits from the live header, not the latch.
  assign commit_wr = sop_q ? hdr_wr : is_wr_q;
  assign fifo_push = grant_a & out_hs & out_tlast & commit_wr;

  always_ff @(posedge clk) begin
    rst_d1_q <= rst;
    if (rst) begin
      state_q    <= StIdle;
      favour_a_q <= 1'b1;
      sop_q      <= 1'b1;
      tag_q      <= '0;
      is_wr_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      favour_a_q <= favour_a_d;
      if (out_hs) sop_q <= out_tlast;
      if (a_sop_hs) begin
        tag_q   <= hdr_tag;
        is_wr_q <= hdr_wr;
      end
    end
  end

  commit_tag_fifo #(
    .DEPTH (COMMIT_DEPTH),
    .WIDTH (8)
  ) u_commit_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (sop_q ? hdr_tag : tag_q),
    .pop       (fifo_pop),
    .pop_data  (fifo_pop_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign unused_fifo_count = ^fifo_count;

  assign rx_b_tvalid = ~fifo_empty & ~rst;
  assign fifo_pop    = rx_b_tvalid & rx_b_tready;
  assign rx_b_tlast  = 1'b1;
  assign rx_b_tuser  = '0;

  always_comb begin
    rx_b_tdata                           = '0;
    rx_b_tdata[HDR_FMT_TYPE_LSB +: 8]    = CPL_NODATA;
    rx_b_tdata[HDR_TAG_LSB +: 8]         = fifo_pop_data;
    for (int unsigned i = 0; i < KEEP_W; i++) begin
      rx_b_tkeep[i] = (i < HDR_BYTES);
    end
  end

endmodule

// File: tb/tb_pcie_tx_ab_commit_merge.sv
module tb_pcie_tx_ab_commit_merge;

  localparam int DW = 512;
  localparam int KW = 64;
  localparam int UW = 10;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
    logic          wr_last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          tx_a_tvalid, tx_a_tready, tx_a_tlast;
  logic [DW-1:0] tx_a_tdata;
  logic [KW-1:0] tx_a_tkeep;
  logic [UW-1:0] tx_a_tuser;
  logic          tx_b_tvalid, tx_b_tready, tx_b_tlast;
  logic [DW-1:0] tx_b_tdata;
  logic [KW-1:0] tx_b_tkeep;
  logic [UW-1:0] tx_b_tuser;
  logic          out_tvalid, out_tready, out_tlast;
  logic [DW-1:0] out_tdata;
  logic [KW-1:0] out_tkeep;
  logic [UW-1:0] out_tuser;
  logic          rx_b_tvalid, rx_b_tready, rx_b_tlast;
  logic [DW-1:0] rx_b_tdata;
  logic [KW-1:0] rx_b_tkeep;
  logic [UW-1:0] rx_b_tuser;

  logic rand_mode, rnd_out, rnd_rx, out_rdy_ctl, rx_rdy_ctl;
  assign out_tready  = rand_mode ? rnd_out : out_rdy_ctl;
  assign rx_b_tready = rand_mode ? rnd_rx : rx_rdy_ctl;

  always #5 clk = ~clk;

  pcie_tx_ab_commit_merge #(
    .DATA_W       (DW),
    .USER_W       (UW),
    .COMMIT_DEPTH (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_a_tvalid (tx_a_tvalid),
    .tx_a_tready (tx_a_tready),
    .tx_a_tlast  (tx_a_tlast),
    .tx_a_tdata  (tx_a_tdata),
    .tx_a_tkeep  (tx_a_tkeep),
    .tx_a_tuser  (tx_a_tuser),
    .tx_b_tvalid (tx_b_tvalid),
    .tx_b_tready (tx_b_tready),
    .tx_b_tlast  (tx_b_tlast),
    .tx_b_tdata  (tx_b_tdata),
    .tx_b_tkeep  (tx_b_tkeep),
    .tx_b_tuser  (tx_b_tuser),
    .out_tvalid  (out_tvalid),
    .out_tready  (out_tready),
    .out_tlast   (out_tlast),
    .out_tdata   (out_tdata),
    .out_tkeep   (out_tkeep),
    .out_tuser   (out_tuser),
    .rx_b_tvalid (rx_b_tvalid),
    .rx_b_tready (rx_b_tready),
    .rx_b_tlast  (rx_b_tlast),
    .rx_b_tdata  (rx_b_tdata),
    .rx_b_tkeep  (rx_b_tkeep),
    .rx_b_tuser  (rx_b_tuser)
  );

  int         n_checks = 0;
  int         n_pass   = 0;
  int         pid_ctr  = 0;
  int         wr_done  = 0;
  int         rx_pops  = 0;
  beat_t      exp_a[$];
  beat_t      exp_b[$];
  logic [7:0] exp_rx[$];
  bit         exp_order[$];

  task automatic chk(input string name, input logic [639:0] act, input logic [639:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_msg(input string name);
    n_checks++;
    $display("FAIL %s: got event with no expectation, expected none", name);
  endtask

  function automatic beat_t make_beat(input bit src, input int pid, input int b, input int n,
                                      input logic [7:0] fmt, input logic [7:0] tag);
    beat_t       e;
    logic [31:0] w;
    logic [63:0] ones;
    ones = '1;
    w = {(src ? 4'hB : 4'hA), pid[11:0], b[7:0], 8'h5A};
    e.data = {16{w}};
    if (b == 0) begin
      e.data[31:24] = fmt;
      e.data[47:40] = tag;
    end
    e.last    = (b == n - 1);
    e.keep    = e.last ? (ones >> (pid % 32)) : ones;
    e.user    = {src, pid[8:0]};
    e.wr_last = !src && e.last && (fmt == 8'h40 || fmt == 8'h60);
    return e;
  endfunction

  function automatic logic [DW-1:0] cpl_data(input logic [7:0] tag);
    logic [DW-1:0] d;
    d = '0;
    d[31:24] = 8'h0A;
    d[47:40] = tag;
    return d;
  endfunction

  task automatic drive(input bit src, input beat_t e);
    if (src) begin
      tx_b_tvalid = 1'b1; tx_b_tdata = e.data; tx_b_tkeep = e.keep;
      tx_b_tuser  = e.user; tx_b_tlast = e.last;
    end else begin
      tx_a_tvalid = 1'b1; tx_a_tdata = e.data; tx_a_tkeep = e.keep;
      tx_a_tuser  = e.user; tx_a_tlast = e.last;
    end
  endtask

  // Drives beats [0, stop_at); if stop_at < n, beat stop_at is left presented.
  task automatic send_pkt(input bit src, input int n, input logic [7:0] fmt,
                          input logic [7:0] tag, input int stop_at);
    beat_t bt[$];
    beat_t e;
    int    pid;
    int    t;
    pid = pid_ctr;
    pid_ctr++;
    for (int b = 0; b < n; b++) begin
      e = make_beat(src, pid, b, n, fmt, tag);
      bt.push_back(e);
      if (b < stop_at) begin
        if (src) exp_b.push_back(e);
        else     exp_a.push_back(e);
      end
    end
    if (!src && stop_at >= n && (fmt == 8'h40 || fmt == 8'h60)) exp_rx.push_back(tag);
    for (int b = 0; b < n; b++) begin
      drive(src, bt[b]);
      if (b == stop_at) return;
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!(src ? tx_b_tready : tx_a_tready) && t < 4000);
      if (t >= 4000) begin
        n_checks++;
        $display("FAIL handshake_timeout: got no tready on src %0d, expected a handshake", src);
      end
      @(posedge clk);
      #1;
    end
    if (src) tx_b_tvalid = 1'b0;
    else     tx_a_tvalid = 1'b0;
  endtask

  // Presents a single-beat A write for one cycle and checks whether it is taken.
  task automatic a_beat_now(input logic [7:0] tag, input bit expect_ready);
    beat_t e;
    e = make_beat(1'b0, pid_ctr, 0, 1, 8'h40, tag);
    pid_ctr++;
    if (expect_ready) begin
      exp_a.push_back(e);
      exp_rx.push_back(tag);
    end
    drive(1'b0, e);
    @(negedge clk);
    chk("a_ready_now", tx_a_tready, expect_ready);
    @(posedge clk);
    #1;
    tx_a_tvalid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_a.size() + exp_b.size() + exp_rx.size()) != 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("drain", exp_a.size() + exp_b.size() + exp_rx.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string name);
    chk(name, {out_tvalid, rx_b_tvalid, tx_a_tready, tx_b_tready}, 4'b0000);
  endtask

  task automatic monitor();
    bit    in_pkt;
    bit    cur_src;
    bit    src;
    beat_t e;
    logic [586:0] obs;
    logic [7:0]   t;
    in_pkt  = 1'b0;
    cur_src = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_pkt  = 1'b0;
        wr_done = rx_pops;
      end else begin
        if (rx_b_tvalid) begin
          chk("rx_not_early", rx_pops < wr_done, 1'b1);
          if (rx_b_tready) begin
            if (exp_rx.size() == 0) begin
              fail_msg("rx_unexpected");
            end else begin
              t = exp_rx.pop_front();
              chk("rx_beat", {rx_b_tdata, rx_b_tkeep, rx_b_tuser, rx_b_tlast},
                  {cpl_data(t), 64'h0000_0000_FFFF_FFFF, 10'd0, 1'b1});
            end
            rx_pops++;
          end
        end
        if (out_tvalid && out_tready) begin
          obs = {out_tdata, out_tkeep, out_tuser, out_tlast};
          if (in_pkt) begin
            src = cur_src;
          end else begin
            if (exp_a.size() != 0 && {exp_a[0].data, exp_a[0].keep, exp_a[0].user,
                                      exp_a[0].last} == obs) src = 1'b0;
            else if (exp_b.size() != 0) src = 1'b1;
            else src = 1'b0;
            if (exp_order.size() != 0) chk("pkt_order", src, exp_order.pop_front());
          end
          if ((src ? exp_b.size() : exp_a.size()) == 0) begin
            fail_msg("out_unexpected");
          end else begin
            e = src ? exp_b.pop_front() : exp_a.pop_front();
            chk(src ? "out_b" : "out_a", obs, {e.data, e.keep, e.user, e.last});
            if (e.wr_last) wr_done++;
          end
          in_pkt  = !out_tlast;
          cur_src = src;
        end
      end
    end
  endtask

  task automatic toggler();
    forever begin
      @(posedge clk);
      #1;
      rnd_out = 1'($urandom_range(0, 1));
      rnd_rx  = 1'($urandom_range(0, 1));
    end
  endtask

  int a_writes;
  int rx_base;

  initial begin
    rst = 1'b1;
    tx_a_tvalid = 1'b0; tx_a_tlast = 1'b0; tx_a_tdata = '0; tx_a_tkeep = '0; tx_a_tuser = '0;
    tx_b_tvalid = 1'b0; tx_b_tlast = 1'b0; tx_b_tdata = '0; tx_b_tkeep = '0; tx_b_tuser = '0;
    rand_mode = 1'b0; rnd_out = 1'b0; rnd_rx = 1'b0; out_rdy_ctl = 1'b1; rx_rdy_ctl = 1'b1;
    fork
      monitor();
      toggler();
    join_none

    // Both sources valid from reset: strict A,B alternation, no commits.
    for (int i = 0; i < 4; i++) begin
      exp_order.push_back(1'b0);
      exp_order.push_back(1'b1);
    end
    fork
      for (int i = 0; i < 4; i++) send_pkt(1'b0, 2, 8'h20, 8'(i), 2);
      for (int i = 0; i < 4; i++) send_pkt(1'b1, 2, 8'h00, 8'(i + 16), 2);
      begin
        repeat (2) begin
          @(negedge clk);
          chk_quiet("rst_quiet_during");
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_quiet("rst_quiet_after");
      end
    join
    wait_drain();
    chk("reads_no_commit", rx_pops, 0);

    // 3-beat MWr64, tag 0x15.
    send_pkt(1'b0, 3, 8'h60, 8'h15, 3);
    wait_drain();

    // FIFO full holds the ninth A write while B still flows.
    rx_rdy_ctl = 1'b0;
    for (int i = 0; i < 8; i++) send_pkt(1'b0, 1, 8'h40, 8'(i), 1);
    fork
      send_pkt(1'b0, 1, 8'h40, 8'h08, 1);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("a_held_full", tx_a_tready, 1'b0);
        end
        @(posedge clk);
        #1;
        send_pkt(1'b1, 2, 8'h30, 8'h77, 2);
        @(negedge clk);
        chk("a_held_after_b", tx_a_tready, 1'b0);
        @(posedge clk);
        #1;
        rx_rdy_ctl = 1'b1;
      end
    join
    wait_drain();

    // Push and pop together at count 7, then fill to 8 without a stall.
    rx_rdy_ctl = 1'b0;
    for (int i = 0; i < 7; i++) a_beat_now(8'(8'h20 + i), 1'b1);
    rx_rdy_ctl = 1'b1;
    a_beat_now(8'h27, 1'b1);
    rx_rdy_ctl = 1'b0;
    a_beat_now(8'h28, 1'b1);
    a_beat_now(8'h29, 1'b0);
    rx_rdy_ctl = 1'b1;
    wait_drain();

    // Reset mid-packet with a pending commit: both discarded, favour back to A.
    rx_rdy_ctl = 1'b0;
    send_pkt(1'b0, 1, 8'h40, 8'h66, 1);
    send_pkt(1'b0, 4, 8'h60, 8'h33, 2);
    rst = 1'b1;
    exp_rx.delete();
    @(negedge clk);
    chk_quiet("rst_mid_during");
    @(posedge clk);
    #1;
    rst = 1'b0;
    tx_a_tvalid = 1'b0;
    rx_rdy_ctl = 1'b1;
    @(negedge clk);
    chk_quiet("rst_mid_after");
    @(posedge clk);
    #1;
    exp_order.push_back(1'b0);
    exp_order.push_back(1'b1);
    fork
      send_pkt(1'b0, 1, 8'h40, 8'h44, 1);
      send_pkt(1'b1, 1, 8'h00, 8'h55, 1);
    join
    wait_drain();

    // 1000 mixed packets under random backpressure.
    a_writes = 0;
    rx_base  = rx_pops;
    rand_mode = 1'b1;
    fork
      for (int i = 0; i < 500; i++) begin
        int          k;
        int          n;
        logic [7:0]  f;
        k = $urandom_range(0, 2);
        n = $urandom_range(1, 4);
        f = (k == 0) ? 8'h40 : (k == 1) ? 8'h60 : 8'h20;
        if (k < 2) a_writes++;
        send_pkt(1'b0, n, f, 8'($urandom), n);
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      for (int i = 0; i < 500; i++) begin
        int          n;
        logic [7:0]  f;
        n = $urandom_range(1, 4);
        f = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'h30;
        send_pkt(1'b1, n, f, 8'($urandom), n);
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
    join
    rand_mode = 1'b0;
    wait_drain();
    chk("commit_count", rx_pops - rx_base, a_writes);
    chk("order_queue_empty", exp_order.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pcie_tx_ab_commit_merge.md
PCIE_TX_AB_COMMIT_MERGE -- requirements
Module: pcie_tx_ab_commit_merge

Interface
REQ-001 SHALL have parameter DATA_W, default 512: tdata width of every stream.
REQ-002 SHALL have parameter USER_W, default 10: tuser width, passed through unmodified.
REQ-003 SHALL have parameter COMMIT_DEPTH, default 8: commit FIFO entries; a power of 2 and at least 2.
REQ-004 SHALL have port clk, input, 1: sole clock.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have ports tx_a_tvalid/tx_a_tready/tx_a_tlast, in/out/in, 1 each: AFU TX A stream handshake (writes, reads, other TLPs).
REQ-007 SHALL have ports tx_a_tdata/tx_a_tkeep/tx_a_tuser, input, DATA_W/DATA_W/8/USER_W: TX A payload; header occupies beat 0.
REQ-008 SHALL have ports tx_b_tvalid/tx_b_tready/tx_b_tlast/tx_b_tdata/tx_b_tkeep/tx_b_tuser, same directions and widths as TX A: AFU TX B stream (reads, interrupts).
REQ-009 SHALL have ports out_tvalid/out_tready/out_tlast/out_tdata/out_tkeep/out_tuser, out/in/out/out/out/out, same widths: merged stream toward the PF/VF mux.
REQ-010 SHALL have ports rx_b_tvalid/rx_b_tready/rx_b_tlast, out/in/out, 1 each: write-commit stream returned to the AFU.
REQ-011 SHALL have ports rx_b_tdata/rx_b_tkeep/rx_b_tuser, output, DATA_W/DATA_W/8/USER_W: commit completion header.

Function
REQ-012 SHALL arbitrate packet-atomically with FSM states IDLE, A_PKT, B_PKT.
REQ-013 In IDLE, SHALL grant by round-robin between eligible A and B, combinationally, in the same cycle; the first beat SHALL forward with zero latency.
REQ-014 Round-robin SHALL favour the source not granted last; after reset, A SHALL be favoured.
REQ-015 A SHALL be eligible only when tx_a_tvalid=1 and the commit FIFO is not full; B SHALL be eligible when tx_b_tvalid=1.
REQ-016 From A_PKT or B_PKT, the FSM SHALL return to IDLE on an out handshake with out_tlast=1; a single-beat packet SHALL leave the FSM in IDLE.
REQ-017 out_* SHALL be a combinational mux of the granted source; out_tvalid=0 when no source is granted.
REQ-018 Granted tready SHALL equal out_tready; the non-granted tready SHALL be 0.
REQ-019 On the A beat-0 handshake, SHALL latch tag = tdata[TAG field] and is_wr = (fmt_type is memory write, 3DW or 4DW).
REQ-020 On the out handshake of tlast for an A packet with is_wr=1, SHALL push the latched tag into the commit FIFO; non-write A packets and all B packets SHALL push nothing.
REQ-021 The commit FIFO SHALL emit one single-beat completion per entry, in push order, with these fields: rx_b_tlast=1; tkeep = all ones for the header bytes and 0 elsewhere; tuser=0; tdata fmt_type = CPL_NODATA; tag = the popped tag; all other bits 0.
REQ-022 rx_b_tvalid SHALL assert no earlier than the cycle after the push.
REQ-023 The FIFO SHALL pop on an rx_b_tvalid & rx_b_tready handshake.
REQ-024 A simultaneous push and pop SHALL keep the count unchanged and lose no data.
REQ-025 FIFO full SHALL block new A grants only; an A packet already in progress SHALL complete, and its push is guaranteed room.
REQ-026 B traffic SHALL never be blocked by commit FIFO state or by rx_b_tready.
REQ-027 Pointers SHALL wrap modulo COMMIT_DEPTH; count width SHALL be clog2(COMMIT_DEPTH)+1.

Reset
REQ-028 rst SHALL force FSM=IDLE, round-robin favour=A, FIFO empty, and latched tag/is_wr=0.
REQ-029 During and in the cycle after rst, out_tvalid, rx_b_tvalid, tx_a_tready and tx_b_tready SHALL be 0.
REQ-030 rst mid-packet SHALL abandon the packet, push no commit, and discard pending commits.

Structure
REQ-031 A shared package SHALL hold: HDR_FMT_TYPE_LSB=24 (8 bits), HDR_TAG_LSB=40 (8 bits), FMT_MWR32=8'h40, FMT_MWR64=8'h60, CPL_NODATA=8'h0A, HDR_BYTES=32.
REQ-032 A single sub-module, commit_tag_fifo (sync FIFO; count, full, empty), SHALL be instantiated once.

Verification
REQ-033 A 3-beat MWr64 with tag 8'h15 on A, with out_tready=1 -> 3 out beats; one rx_b completion with fmt 8'h0A and tag 8'h15, asserted no earlier than the cycle after out tlast.
REQ-034 A and B both valid from reset, each sending 2-beat reads, with 4 packets per source -> out order A,B,A,B,... with no interleaved beats and zero rx_b commits.
REQ-035 rx_b_tready=0 and 9 single-beat A writes with tags 0..8 -> 8 pass; the 9th is held (tx_a_tready=0) while B still flows; raising rx_b_tready -> tags 0..8 return in order.
REQ-036 Push and pop in the same cycle at count=COMMIT_DEPTH-1 -> count unchanged; no spurious full stall.
REQ-037 rst asserted on beat 2 of a 4-beat A write -> no commit emitted; the next A packet is granted cleanly with favour=A.
REQ-038 out_tready toggled randomly for 1000 mixed packets -> out stream is bit-exact to the per-source scoreboard; commit count equals the A write count.
